// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } stateT;

    localparam int unsigned WIDTH_DEF = 32;

    // Iteration counter must hold values up to WIDTH-1 with headroom.
    localparam int unsigned CNT_W = $clog2(WIDTH_DEF) + 1;

endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// One restoring-division step on {remainder, quotient} against a divisor magnitude.
module div_restore_step
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;

    // Shift in the next dividend bit, trial-subtract, keep the result only when no borrow.
    always_comb begin
        remShift = {remIn, quoIn[WIDTH-1]};
        diff     = remShift - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            remOut = diff[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = remShift[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential multiply (radix-2 Booth) / restoring divide unit feeding HI/LO.
// Optional MULT_DIV_UNSIGNED_EN adds is_unsigned for MULTU/DIVU behaviour.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    stateT            state, stateNext;
    logic [CntW-1:0]  cnt, cntNext;
    logic [WIDTH:0]   workHi, workHiNext;
    logic [WIDTH-1:0] workLo, workLoNext;
    logic             workBit, workBitNext;
    logic [WIDTH-1:0] operand, operandNext;
    logic             opDiv, opDivNext;
    logic             negQuo, negQuoNext;
    logic             negRem, negRemNext;
    logic [WIDTH-1:0] hiNext, loNext;
    logic             busyNext, doneNext, divZeroNext;

    logic             startSigned, aNeg, bNeg;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] stepRem, stepQuo;
    logic [WIDTH:0]   boothSum, mExt;
    logic [WIDTH:0]   boothHi;
    logic [WIDTH-1:0] boothLo;
    logic             lastIter;

`ifdef MULT_DIV_UNSIGNED_EN
    logic             mulUnsigned, mulUnsignedNext;
    assign startSigned = !is_unsigned;
`else
    assign startSigned = 1'b1;
`endif

    // Operand sign and magnitude for the divider.
    assign aNeg = startSigned & a_in[WIDTH-1];
    assign bNeg = startSigned & b_in[WIDTH-1];
    assign magA = aNeg ? -a_in : a_in;
    assign magB = bNeg ? -b_in : b_in;
    assign lastIter = (cnt == CntW'(WIDTH - 1));

    div_restore_step #(.WIDTH(WIDTH)) uDivStep (
        .remIn  (workHi[WIDTH-1:0]),
        .quoIn  (workLo),
        .divisor(operand),
        .remOut (stepRem),
        .quoOut (stepQuo)
    );

    // One Booth iteration: add/subtract multiplicand, then arithmetic shift right.
    always_comb begin
        mExt     = {operand[WIDTH-1], operand};
        boothSum = workHi;
        case ({workLo[0], workBit})
            2'b01:   boothSum = workHi + mExt;
            2'b10:   boothSum = workHi - mExt;
            default: boothSum = workHi;
        endcase
        boothHi = {boothSum[WIDTH], boothSum[WIDTH:1]};
        boothLo = {boothSum[0], workLo[WIDTH-1:1]};
`ifdef MULT_DIV_UNSIGNED_EN
        if (mulUnsigned) begin
            mExt     = {1'b0, operand};
            boothSum = workHi + (workLo[0] ? mExt : '0);
            boothHi  = {1'b0, boothSum[WIDTH:1]};
            boothLo  = {boothSum[0], workLo[WIDTH-1:1]};
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        workHiNext  = workHi;
        workLoNext  = workLo;
        workBitNext = workBit;
        operandNext = operand;
        opDivNext   = opDiv;
        negQuoNext  = negQuo;
        negRemNext  = negRem;
        hiNext      = hi_out;
        loNext      = lo_out;
        busyNext    = busy;
        doneNext    = 1'b0;
        divZeroNext = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
        mulUnsignedNext = mulUnsigned;
`endif
        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (mult_start) begin
                    stateNext   = MULT;
                    cntNext     = '0;
                    workHiNext  = '0;
                    workLoNext  = b_in;
                    workBitNext = 1'b0;
                    operandNext = a_in;
                    opDivNext   = 1'b0;
                    busyNext    = 1'b1;
`ifdef MULT_DIV_UNSIGNED_EN
                    mulUnsignedNext = is_unsigned;
`endif
                end else if (div_start) begin
                    if (b_in == '0) begin
                        divZeroNext = 1'b1;
                    end else begin
                        stateNext   = DIV;
                        cntNext     = '0;
                        workHiNext  = '0;
                        workLoNext  = magA;
                        workBitNext = 1'b0;
                        operandNext = magB;
                        opDivNext   = 1'b1;
                        negQuoNext  = aNeg ^ bNeg;
                        negRemNext  = aNeg;
                        busyNext    = 1'b1;
                    end
                end
            end
            MULT: begin
                workHiNext  = boothHi;
                workLoNext  = boothLo;
                workBitNext = workLo[0];
                cntNext     = cnt + CntW'(1);
                if (lastIter) begin
                    stateNext = FINISH;
                    busyNext  = 1'b0;
                end
            end
            DIV: begin
                workHiNext = {1'b0, stepRem};
                workLoNext = stepQuo;
                cntNext    = cnt + CntW'(1);
                if (lastIter) begin
                    stateNext = FINISH;
                    busyNext  = 1'b0;
                end
            end
            FINISH: begin
                stateNext = IDLE;
                doneNext  = 1'b1;
                if (opDiv) begin
                    loNext = negQuo ? -workLo : workLo;
                    hiNext = negRem ? -workHi[WIDTH-1:0] : workHi[WIDTH-1:0];
                end else begin
                    loNext = workLo;
                    hiNext = workHi[WIDTH-1:0];
                end
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            workHi   <= '0;
            workLo   <= '0;
            workBit  <= 1'b0;
            operand  <= '0;
            opDiv    <= 1'b0;
            negQuo   <= 1'b0;
            negRem   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
            mulUnsigned <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            workHi   <= workHiNext;
            workLo   <= workLoNext;
            workBit  <= workBitNext;
            operand  <= operandNext;
            opDiv    <= opDivNext;
            negQuo   <= negQuoNext;
            negRem   <= negRemNext;
            hi_out   <= hiNext;
            lo_out   <= loNext;
            busy     <= busyNext;
            done     <= doneNext;
            div_zero <= divZeroNext;
`ifdef MULT_DIV_UNSIGNED_EN
            mulUnsigned <= mulUnsignedNext;
`endif
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (signed build).
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } resT;

    logic         clk = 1'b0;
    logic         reset;
    logic         mult_start;
    logic         div_start;
    logic         is_unsigned;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy;
    logic         done;
    logic         div_zero;

    int  checks   = 0;
    int  failures = 0;
    resT sb[$];
    resT lastRes;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned(is_unsigned),
`endif
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    function automatic resT mulModel(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb, p;
        resT r;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    function automatic resT divModel(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb, q, m;
        resT r;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        q  = pa / pb;
        m  = pa % pb;
        r.hi = m[31:0];
        r.lo = q[31:0];
        return r;
    endfunction

    // Drive one start strobe and observe a fixed 41-cycle window after the sampling edge.
    task automatic runOp(input logic doMul, input logic doDiv,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int injectAt,
                         output int doneCyc, output int doneCnt, output int busyCnt,
                         output int dzCnt, output logic [W-1:0] hiObs, output logic [W-1:0] loObs);
        doneCyc = -1; doneCnt = 0; busyCnt = 0; dzCnt = 0;
        hiObs = hi_out; loObs = lo_out;
        a_in = a; b_in = b; mult_start = doMul; div_start = doDiv;
        @(posedge clk); #1;
        mult_start = 1'b0; div_start = 1'b0;
        a_in = ~a; b_in = b ^ 32'h5A5A_0001;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busyCnt++;
            if (div_zero) dzCnt++;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc = cyc;
                    hiObs = hi_out;
                    loObs = lo_out;
                end
            end
            div_start = (cyc == injectAt);
        end
        div_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; is_unsigned = 1'b0;
        a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lastRes = '0;
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_divzero got=%b exp=0", div_zero); end
    endtask

    task automatic test_mult_sign();
        int dc, dn, bc, dz; logic [W-1:0] h, l; resT e;
        sb.push_back(mulModel(32'hFFFF_FFF9, 32'd3));
        runOp(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd3, -1, dc, dn, bc, dz, h, l);
        checks++; if (dc != 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", dc); end
        checks++; if (bc != 32) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=32", bc); end
        checks++; if (dn != 1) begin failures++; $display("FAIL mult_done_count got=%0d exp=1", dn); end
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL mult_sign_sb got=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            lastRes = e;
            if (h !== e.hi || l !== e.lo) begin
                failures++; $display("FAIL mult_sign got=%h_%h exp=%h_%h", h, l, e.hi, e.lo);
            end
        end
        checks++; if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
            failures++; $display("FAIL mult_hold got=%h_%h exp=ffffffff_ffffffeb", hi_out, lo_out);
        end
    endtask

    task automatic test_div_sign();
        int dc, dn, bc, dz; logic [W-1:0] h, l; resT e;
        logic [W-1:0] av[2], bv[2];
        av[0] = 32'd7;         bv[0] = 32'hFFFF_FFFE;
        av[1] = 32'hFFFF_FFF9; bv[1] = 32'd2;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(divModel(av[i], bv[i]));
            runOp(1'b0, 1'b1, av[i], bv[i], -1, dc, dn, bc, dz, h, l);
            checks++; if (dc != 33) begin failures++; $display("FAIL div_latency_%0d got=%0d exp=33", i, dc); end
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL div_sign_sb_%0d got=empty exp=entry", i); end
            else begin
                e = sb.pop_front();
                lastRes = e;
                if (h !== e.hi || l !== e.lo) begin
                    failures++; $display("FAIL div_sign_%0d got=%h_%h exp=%h_%h", i, h, l, e.hi, e.lo);
                end
            end
        end
        checks++; if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
            failures++; $display("FAIL div_neg_dividend got=%h_%h exp=ffffffff_fffffffd", hi_out, lo_out);
        end
    endtask

    task automatic test_div_zero();
        int dc, dn, bc, dz; logic [W-1:0] h, l;
        runOp(1'b0, 1'b1, 32'd5, 32'd0, -1, dc, dn, bc, dz, h, l);
        checks++; if (dz != 1) begin failures++; $display("FAIL divzero_pulse got=%0d exp=1", dz); end
        checks++; if (bc != 0) begin failures++; $display("FAIL divzero_busy got=%0d exp=0", bc); end
        checks++; if (dn != 0) begin failures++; $display("FAIL divzero_done got=%0d exp=0", dn); end
        checks++; if (hi_out !== lastRes.hi || lo_out !== lastRes.lo) begin
            failures++; $display("FAIL divzero_hold got=%h_%h exp=%h_%h", hi_out, lo_out, lastRes.hi, lastRes.lo);
        end
    endtask

    task automatic test_overflow();
        int dc, dn, bc, dz; logic [W-1:0] h, l; resT e;
        sb.push_back(divModel(32'h8000_0000, 32'hFFFF_FFFF));
        runOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, dc, dn, bc, dz, h, l);
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL div_overflow_sb got=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            if (h !== e.hi || l !== e.lo || dn != 1) begin
                failures++; $display("FAIL div_overflow got=%h_%h done=%0d exp=%h_%h done=1", h, l, dn, e.hi, e.lo);
            end
        end
        sb.push_back(mulModel(32'h8000_0000, 32'h8000_0000));
        runOp(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, dc, dn, bc, dz, h, l);
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL mult_minmin_sb got=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            lastRes = e;
            if (h !== e.hi || l !== e.lo || dn != 1) begin
                failures++; $display("FAIL mult_minmin got=%h_%h done=%0d exp=%h_%h done=1", h, l, dn, e.hi, e.lo);
            end
        end
        checks++; if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin
            failures++; $display("FAIL mult_minmin_const got=%h_%h exp=40000000_00000000", hi_out, lo_out);
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, bc, dz; logic [W-1:0] h, l; resT e;
        sb.push_back(mulModel(32'd6, 32'd4));
        runOp(1'b1, 1'b1, 32'd6, 32'd4, -1, dc, dn, bc, dz, h, l);
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL simult_sb got=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            if (h !== e.hi || l !== e.lo) begin
                failures++; $display("FAIL simult_mult_wins got=%h_%h exp=%h_%h", h, l, e.hi, e.lo);
            end
        end
        checks++; if (dn != 1) begin failures++; $display("FAIL simult_done_count got=%0d exp=1", dn); end
        sb.push_back(mulModel(32'hFFFF_FF00, 32'd1000));
        runOp(1'b1, 1'b0, 32'hFFFF_FF00, 32'd1000, 10, dc, dn, bc, dz, h, l);
        checks++; if (dn != 1 || dc != 33) begin
            failures++; $display("FAIL busy_start_ignored got=done%0d@%0d exp=done1@33", dn, dc);
        end
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL busy_start_sb got=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            lastRes = e;
            if (h !== e.hi || l !== e.lo) begin
                failures++; $display("FAIL busy_start_result got=%h_%h exp=%h_%h", h, l, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, dn, bc, dz; logic [W-1:0] h, l; resT e;
        int doneSeen;
        sb.push_back(mulModel(32'd5, 32'd7));
        a_in = 32'd5; b_in = 32'd7; mult_start = 1'b1;
        @(posedge clk); #1 mult_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        lastRes = '0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
            failures++; $display("FAIL rstmid_outputs got=%h_%h exp=0_0", hi_out, lo_out);
        end
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) doneSeen++;
            @(posedge clk); #1;
        end
        checks++; if (doneSeen != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", doneSeen); end
        sb.push_back(mulModel(32'd2, 32'd3));
        runOp(1'b1, 1'b0, 32'd2, 32'd3, -1, dc, dn, bc, dz, h, l);
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL rstmid_fresh_sb got=empty exp=entry"); end
        else begin
            e = sb.pop_front();
            lastRes = e;
            if (h !== e.hi || l !== e.lo || l !== 32'd6 || dn != 1) begin
                failures++; $display("FAIL rstmid_fresh got=%h_%h exp=%h_%h", h, l, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_random();
        int dc, dn, bc, dz; logic [W-1:0] h, l, a, b; resT e; logic isDiv;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            if (i % 4 == 1) b = W'($urandom_range(1, 300));
            if (i % 4 == 3) b = -W'($urandom_range(1, 300));
            isDiv = (i % 2 == 1);
            if (isDiv && b == '0) b = 32'd1;
            sb.push_back(isDiv ? divModel(a, b) : mulModel(a, b));
            runOp(!isDiv, isDiv, a, b, -1, dc, dn, bc, dz, h, l);
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL random_sb_%0d got=empty exp=entry", i); end
            else begin
                e = sb.pop_front();
                lastRes = e;
                if (h !== e.hi || l !== e.lo || dc != 33) begin
                    failures++;
                    $display("FAIL random_%0d a=%h b=%h got=%h_%h@%0d exp=%h_%h@33", i, a, b, h, l, dc, e.hi, e.lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_sign();
        test_div_sign();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Sequential signed multiply/divide unit for the multicycle MIPS datapath. It sits directly upstream of the HI and LO registers and feeds their write data. Operands come from the A and B registers. Start strobes come from the control FSM as multControl and divControl. The unit reports completion with done and flags divide-by-zero to the FSM, which then takes the exception path.

Parameters:
WIDTH, 32, operand width; hi_out and lo_out are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
mult_start  input  1  one-cycle strobe: start signed multiply of a_in by b_in
div_start  input  1  one-cycle strobe: start signed divide of a_in by b_in
a_in  input  WIDTH  multiplicand / dividend
b_in  input  WIDTH  multiplier / divisor
hi_out  output  WIDTH  multiply: product[63:32]; divide: remainder
lo_out  output  WIDTH  multiply: product[31:0]; divide: quotient
busy  output  1  high while an operation is iterating
done  output  1  one-cycle pulse, result valid on hi_out/lo_out
div_zero  output  1  one-cycle pulse, divide with b_in==0 rejected

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - reset is synchronous and active-high.
  - On reset: state=IDLE; hi_out=0, lo_out=0, busy=0, done=0, div_zero=0; iteration counter=0.
- States:
  - IDLE -> MULT on mult_start.
  - IDLE -> DIV on div_start with b_in!=0.
  - MULT/DIV -> FINISH after WIDTH iterations.
  - FINISH -> IDLE.
- Operand capture: start strobes are sampled only in IDLE. a_in and b_in are captured on the same edge; later changes are ignored.
- Multiply:
  - Radix-2 Booth, one iteration per cycle, WIDTH cycles.
  - 64-bit two's-complement product.
- Divide:
  - Restoring divide on operand magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Sign fix-up happens in FINISH.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Latency: start sampled on edge t -> busy high from t+1 through t+WIDTH. FINISH occupies t+WIDTH+1: done=1, hi_out/lo_out updated on that edge.
- Result hold: hi_out/lo_out hold their last result until the next done or reset. They never show intermediate values.
- Divide by zero:
  - div_start with b_in==0 in IDLE -> div_zero=1 for exactly the next cycle.
  - State stays IDLE; hi_out/lo_out unchanged; done not asserted.
- Overflow: 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. This is wrap, no flag.
- Simultaneous mult_start and div_start in IDLE: multiply wins; the divide request is dropped.
- Starts while busy or in FINISH are ignored, with no queueing.
- reset mid-operation: aborts immediately; outputs take reset values the next cycle; no done.
- busy is low in IDLE and FINISH.

Optional Feature:
MULT_DIV_UNSIGNED_EN
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with the start strobe.
  - When high, operands are treated as unsigned (MULTU/DIVU): no Booth sign extension, no divide sign fix-up.
  - Latency is identical.
- Undefined:
  - The port is absent and all operations are signed.

Decomposition:
- Shared package mult_div_pkg holds:
  - State enum {IDLE, MULT, DIV, FINISH}.
  - Constant WIDTH_DEF=32.
  - Counter width localparam $clog2(WIDTH)+1.
- Natural sub-module: div_restore_step. It is combinational: one restoring subtract/shift on {remainder, quotient} against the divisor magnitude. It is instantiated once inside mult_div_unit; the Booth step stays inline.

Test Plan:
- Multiply sign: a=0xFFFFFFF9 (-7), b=3, mult_start -> done exactly 33 cycles later; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- Divide sign fix-up: a=7, b=0xFFFFFFFE (-2), div_start -> lo_out=0xFFFFFFFD (-3), hi_out=1; then a=0xFFFFFFF9, b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- Divide by zero: a=5, b=0, div_start -> div_zero high one cycle, busy stays 0, no done, hi/lo keep the prior result.
- Overflow: a=0x80000000, b=0xFFFFFFFF, div_start -> lo_out=0x80000000, hi_out=0; then a=0x80000000, b=0x80000000, mult_start -> hi_out=0x40000000, lo_out=0.
- Simultaneous and busy starts: mult_start and div_start together with a=6, b=4 -> product hi=0, lo=24. A div_start pulsed mid-operation is ignored, and exactly one done is seen.
- Reset mid-operation: reset asserted 10 cycles into a multiply -> next cycle busy=0, hi_out=lo_out=0, no done; a fresh mult_start of 2*3 gives lo_out=6.
